// File: rtl/lzw_pkg.sv
// lzw_pkg
// Shared definitions for the LZW compression core and its output stages.
//   HASH_WIDTH      : maximum LZW code width (bits)
//   MIN_WIDTH       : code width used right after reset
//   OUT_WIDTH       : packed output symbol width
//   FIRST_FREE_CODE : first dictionary code after the 256 literals
//   packer_state_t  : state encoding of the code packer
//   code_width_of() : code width implied by the next free dictionary code
package lzw_pkg;

  localparam int HASH_WIDTH = 12;
  localparam int MIN_WIDTH  = 9;
  localparam int OUT_WIDTH  = 8;

  localparam logic [HASH_WIDTH-1:0] FIRST_FREE_CODE = 12'd256;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } packer_state_t;

  // The width grows one bit each time the next free code no longer fits
  // in the current width.
  function automatic logic [3:0] code_width_of(input logic [HASH_WIDTH-1:0] next_code);
    if (next_code <= 12'd511) begin
      return 4'(MIN_WIDTH);
    end else if (next_code <= 12'd1023) begin
      return 4'(MIN_WIDTH + 1);
    end else if (next_code <= 12'd2047) begin
      return 4'(MIN_WIDTH + 2);
    end
    return 4'(MIN_WIDTH + 3);
  endfunction

endpackage

// File: rtl/lzw_code_packer.sv
// lzw_code_packer
// Packs variable-width (9..12 bit) LZW codes LSB-first into a continuous
// bitstream and emits it as bytes under a valid/ready handshake. On end of
// file it drains the accumulator, zero-pads the final partial byte and
// raises done.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   code_in      : code from the core, qualified by code_valid / code_ready
//   eof          : single-cycle pulse, no more codes follow
//   byte_out     : packed byte, qualified by byte_valid / byte_ready
//   code_width   : width applied to the next incoming code
//   byte_count   : bytes transferred since reset (wraps)
//   err          : sticky, a code did not fit in the current width
//   done         : flush complete
module lzw_code_packer
  import lzw_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [HASH_WIDTH-1:0] code_in,
  input  logic                  code_valid,
  output logic                  code_ready,
  input  logic                  eof,
  output logic [OUT_WIDTH-1:0]  byte_out,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic [3:0]            code_width,
  output logic [15:0]           byte_count,
  output logic                  err,
  output logic                  done
);

  localparam int ACC_WIDTH = HASH_WIDTH + OUT_WIDTH;

  packer_state_t         state;
  packer_state_t         state_next;
  logic [ACC_WIDTH-1:0]  acc;
  logic [4:0]            bit_count;
  logic [HASH_WIDTH-1:0] next_code;
  logic                  eof_pending;

  logic                  accept;
  logic                  xfer;
  logic [HASH_WIDTH-1:0] code_mask;
  logic [HASH_WIDTH-1:0] code_masked;
  logic                  code_over;
  logic [4:0]            drop_bits;

  assign code_width = code_width_of(next_code);

  // At width 12 the shifted one falls off the top, so the mask wraps to all ones.
  assign code_mask   = (HASH_WIDTH'(1) << code_width) - HASH_WIDTH'(1);
  assign code_masked = code_in & code_mask;
  assign code_over   = |(code_in & ~code_mask);

  assign accept   = code_valid & code_ready;
  assign xfer     = byte_valid & byte_ready;
  assign byte_out = acc[OUT_WIDTH-1:0];

  // A flushed partial byte only consumes the bits that are actually left.
  assign drop_bits = (bit_count < 5'd8) ? bit_count : 5'd8;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake outputs, all decoded from registered state.
  // EOF goes straight to FLUSH; FLUSH keeps emitting whatever RUN had left.
  always_comb begin
    state_next = state;
    code_ready = 1'b0;
    byte_valid = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        state_next = ST_RUN;
      end
      ST_RUN: begin
        code_ready = !eof_pending && (bit_count < 5'd8);
        byte_valid = (bit_count >= 5'd8);
        if (eof) begin
          state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        byte_valid = (bit_count != 5'd0);
        if (bit_count == 5'd0) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Accumulator datapath. Accept needs fewer than 8 buffered bits and a
  // transfer needs at least one byte's worth in RUN, so the two never
  // collide there; in FLUSH code_ready is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      bit_count   <= '0;
      next_code   <= FIRST_FREE_CODE;
      eof_pending <= 1'b0;
      byte_count  <= '0;
      err         <= 1'b0;
    end else begin
      if (accept) begin
        acc       <= acc | (ACC_WIDTH'(code_masked) << bit_count);
        bit_count <= bit_count + 5'(code_width);
        if (next_code != '1) begin
          next_code <= next_code + 12'd1;
        end
        if (code_over) begin
          err <= 1'b1;
        end
      end else if (xfer) begin
        acc        <= acc >> OUT_WIDTH;
        bit_count  <= bit_count - drop_bits;
        byte_count <= byte_count + 16'd1;
      end
      if (state == ST_RUN && eof) begin
        eof_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lzw_code_packer.sv
// tb_lzw_code_packer
// Self-checking bench for lzw_code_packer: a table of short hand-computed
// streams, hand-written corner sequences (backpressure, width growth,
// mid-stream reset, empty EOF) and randomized streams checked against a
// bit-queue reference model.
module tb_lzw_code_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] code_in;
  logic        code_valid;
  logic        code_ready;
  logic        eof;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic [3:0]  code_width;
  logic [15:0] byte_count;
  logic        err;
  logic        done;

  logic ready_level = 1'b1;
  logic rand_ready  = 1'b0;
  logic rnd_bit     = 1'b1;

  int total = 0;
  int bad   = 0;

  logic [11:0] acc_codes[$];
  logic [7:0]  got_bytes[$];
  logic [7:0]  exp_bytes[$];
  logic        exp_err;
  int          valid_seen;
  bit          mon_on = 1'b0;

  typedef struct {
    logic [11:0] c0;
    logic [11:0] c1;
    int          ncodes;
    bit          eof_last;
    int          nbytes;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic        err;
  } vec_t;

  vec_t vecs[6];

  assign byte_ready = rand_ready ? rnd_bit : ready_level;

  lzw_code_packer dut (
    .clk        (clk),
    .rst        (rst),
    .code_in    (code_in),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .eof        (eof),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .code_width (code_width),
    .byte_count (byte_count),
    .err        (err),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 1) == 1);
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic note_timeout(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s actual=timeout required=event", name);
  endtask

  // Width rule: the next free code is 256 plus the number of codes taken,
  // saturating at 4095.
  function automatic int width_for(input int n_accepted);
    int nc;
    nc = 256 + n_accepted;
    if (nc > 4095) nc = 4095;
    if (nc <= 511) return 9;
    if (nc <= 1023) return 10;
    if (nc <= 2047) return 11;
    return 12;
  endfunction

  // Reference: lay every code's low w bits into one bit list, then cut it
  // into bytes with the last one zero-padded.
  function automatic void build_expected();
    bit         bits[$];
    int         w;
    logic [7:0] v;
    exp_bytes.delete();
    exp_err = 1'b0;
    foreach (acc_codes[i]) begin
      w = width_for(i);
      if ((acc_codes[i] >> w) != 0) exp_err = 1'b1;
      for (int b = 0; b < w; b++) bits.push_back(acc_codes[i][b]);
    end
    while (bits.size() > 0) begin
      v = '0;
      for (int b = 0; b < 8; b++) begin
        if (bits.size() > 0) v[b] = bits.pop_front();
      end
      exp_bytes.push_back(v);
    end
  endfunction

  // Observes handshakes half a cycle before the edge that completes them.
  always @(negedge clk) begin
    if (mon_on) begin
      if (byte_valid) valid_seen++;
      if (code_valid && code_ready) begin
        checkOutput("width_at_accept", code_width, width_for(acc_codes.size()));
        acc_codes.push_back(code_in);
      end
      if (byte_valid && byte_ready) begin
        checkOutput("count_at_xfer", byte_count, got_bytes.size() & 16'hFFFF);
        got_bytes.push_back(byte_out);
      end
    end
  end

  // Entered and left just after a rising edge.
  task automatic do_reset();
    mon_on     = 1'b0;
    code_valid = 1'b0;
    eof        = 1'b0;
    code_in    = '0;
    rst        = 1'b1;
    #1;
    checkOutput("rst_code_ready", code_ready, 0);
    checkOutput("rst_byte_valid", byte_valid, 0);
    checkOutput("rst_byte_out", byte_out, 0);
    checkOutput("rst_code_width", code_width, 9);
    checkOutput("rst_byte_count", byte_count, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    acc_codes.delete();
    got_bytes.delete();
    valid_seen = 0;
    mon_on     = 1'b1;
    @(negedge clk);
    checkOutput("ready_cycle1", code_ready, 0);
    @(negedge clk);
    checkOutput("ready_cycle2", code_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [11:0] c, input bit with_eof);
    bit ok;
    ok         = 1'b0;
    code_in    = c;
    code_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = code_ready;
    end
    if (!ok) note_timeout("accept_wait");
    eof = with_eof;
    @(posedge clk);
    #1;
    code_valid = 1'b0;
    eof        = 1'b0;
  endtask

  task automatic pulse_eof();
    eof = 1'b1;
    @(posedge clk);
    #1;
    eof = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = done;
    end
    if (!ok) note_timeout("done_wait");
    @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string tag);
    build_expected();
    checkOutput({tag, "_nbytes"}, got_bytes.size(), exp_bytes.size());
    foreach (exp_bytes[i]) begin
      if (i < got_bytes.size()) checkOutput($sformatf("%s_byte%0d", tag, i), got_bytes[i], exp_bytes[i]);
    end
    checkOutput({tag, "_byte_count"}, byte_count, exp_bytes.size() & 16'hFFFF);
    checkOutput({tag, "_err"}, err, exp_err);
    checkOutput({tag, "_done"}, done, 1);
  endtask

  task automatic random_run(input string tag, input int n, input bit use_rand_ready, input int max_gap);
    logic [11:0] c;
    int          w;
    bit          eof_last;
    rand_ready = use_rand_ready;
    eof_last   = ($urandom_range(0, 1) == 1);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        @(posedge clk);
        #1;
      end
      w = width_for(acc_codes.size());
      if ($urandom_range(0, 49) == 0) c = 12'($urandom_range(0, 4095));
      else c = 12'($urandom_range(0, (1 << w) - 1));
      applyStimulus(c, eof_last && (i == n - 1));
    end
    if (!eof_last) pulse_eof();
    wait_done(20000);
    check_stream(tag);
    rand_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] eb[3];
    rst        = 1'b1;
    code_in    = '0;
    code_valid = 1'b0;
    eof        = 1'b0;

    vecs[0] = '{12'h041, 12'h042, 2, 1'b0, 3, 8'h41, 8'h84, 8'h00, 1'b0};
    vecs[1] = '{12'h3FF, 12'h000, 1, 1'b0, 2, 8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{12'h1FF, 12'h1FF, 2, 1'b1, 3, 8'hFF, 8'hFF, 8'h03, 1'b0};
    vecs[3] = '{12'h0AA, 12'h000, 1, 1'b1, 2, 8'hAA, 8'h00, 8'h00, 1'b0};
    vecs[4] = '{12'h155, 12'h0F0, 2, 1'b1, 3, 8'h55, 8'hE1, 8'h01, 1'b0};
    vecs[5] = '{12'hFFF, 12'h000, 2, 1'b0, 3, 8'hFF, 8'h01, 8'h00, 1'b1};

    @(posedge clk);
    #1;

    // Hand-computed short streams.
    for (int v = 0; v < 6; v++) begin
      ready_level = 1'b1;
      rand_ready  = 1'b0;
      do_reset();
      applyStimulus(vecs[v].c0, vecs[v].eof_last && vecs[v].ncodes == 1);
      if (vecs[v].ncodes == 2) applyStimulus(vecs[v].c1, vecs[v].eof_last);
      if (!vecs[v].eof_last) pulse_eof();
      wait_done(200);
      eb[0] = vecs[v].b0;
      eb[1] = vecs[v].b1;
      eb[2] = vecs[v].b2;
      checkOutput($sformatf("vec%0d_nbytes", v), got_bytes.size(), vecs[v].nbytes);
      for (int i = 0; i < vecs[v].nbytes; i++) begin
        if (i < got_bytes.size()) checkOutput($sformatf("vec%0d_byte%0d", v, i), got_bytes[i], eb[i]);
      end
      checkOutput($sformatf("vec%0d_byte_count", v), byte_count, vecs[v].nbytes);
      checkOutput($sformatf("vec%0d_err", v), err, vecs[v].err);
      checkOutput($sformatf("vec%0d_done", v), done, 1);
    end

    // Backpressure holds the byte and blocks further codes.
    ready_level = 1'b0;
    do_reset();
    applyStimulus(12'h041, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_valid", byte_valid, 1);
      checkOutput("bp_byte", byte_out, 8'h41);
      checkOutput("bp_code_ready", code_ready, 0);
      checkOutput("bp_count", byte_count, 0);
    end
    @(posedge clk);
    #1;
    ready_level = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_count_after", byte_count, 1);
    pulse_eof();
    wait_done(200);
    check_stream("bp");

    // Width growth after 256 codes.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      if (i % 64 == 0 || i == 255) checkOutput("w9_during", code_width, 9);
      applyStimulus(12'h000, 1'b0);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("w10_after", code_width, 10);
    checkOutput("w_288_bytes", got_bytes.size(), 288);
    applyStimulus(12'h155, 1'b0);
    pulse_eof();
    wait_done(200);
    check_stream("width");

    // Reset in the middle of a stream discards buffered bits.
    do_reset();
    for (int i = 0; i < 5; i++) applyStimulus(12'($urandom_range(0, 511)), 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("mid_pre_count", byte_count, 5);
    #2;
    do_reset();
    applyStimulus(12'h041, 1'b0);
    pulse_eof();
    wait_done(200);
    checkOutput("mid_first_byte", got_bytes.size() > 0 ? got_bytes[0] : 8'hXX, 8'h41);
    check_stream("mid");

    // EOF with nothing buffered.
    do_reset();
    eof = 1'b1;
    @(posedge clk);
    #1;
    eof = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("eof0_done", done, 1);
    checkOutput("eof0_no_valid", valid_seen, 0);
    code_in    = 12'h041;
    code_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    code_valid = 1'b0;
    checkOutput("eof0_ignored", acc_codes.size(), 0);
    checkOutput("eof0_byte_count", byte_count, 0);
    checkOutput("eof0_valid", byte_valid, 0);
    checkOutput("eof0_done_held", done, 1);

    // Randomized streams against the reference model.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      random_run($sformatf("rnd%0d", r), $urandom_range(50, 900), 1'b1, 2);
    end

    // Long stream past the 4095 saturation point at full rate.
    ready_level = 1'b1;
    do_reset();
    random_run("long", 3900, 1'b0, 0);
    checkOutput("long_width12", code_width, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
